// File: rtl/uart_rx_fifo_pkg.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo_pkg
// Shared constants for the UART receive path: parity mode codes, FSM state
// encodings and the baud-tick divider calculation.
// No ports (package).
// ----------------------------------------------------------------------------
package uart_rx_fifo_pkg;

    // Parity mode codes (value of the PARITY parameter)
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Receiver FSM state encodings
    localparam int         ST_W          = 3;
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_START      = 3'd1;
    localparam logic [2:0] ST_DATA       = 3'd2;
    localparam logic [2:0] ST_PARITY     = 3'd3;
    localparam logic [2:0] ST_STOP       = 3'd4;
    localparam logic [2:0] ST_BREAK_WAIT = 3'd5;

    // Clocks per oversample tick; integer truncation is intended.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is always
// presented on o_rd_data; a pop advances it on the next clock edge.
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-low
//   i_wr_en    in   push i_wr_data (dropped when full unless a pop happens)
//   i_wr_data  in   WIDTH-bit write data
//   i_rd_en    in   pop head (ignored when empty)
//   o_rd_data  out  head entry
//   o_empty    out  no entries held
//   o_full     out  DEPTH entries held
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_pop;
    logic w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));

    // A pop on an empty FIFO is ignored; a push into a full FIFO is only
    // accepted when a pop frees the slot in the same clock.
    assign w_pop  = i_rd_en & ~o_empty;
    assign w_push = i_wr_en & (~o_full | w_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
// Oversampling UART receiver with configurable word/parity/stop format,
// error pulses and a FWFT receive FIFO for the host-command channel.
//
// State table
//   state       | meaning
//   ST_IDLE      | line idle, waiting for a synchronised 1->0 edge
//   ST_START     | validating start bit at its mid-point
//   ST_DATA      | sampling DATA_BITS data bits, LSB first
//   ST_PARITY    | sampling the parity bit
//   ST_STOP      | sampling STOP_BITS stop bits, deciding push/error
//   ST_BREAK_WAIT| framing error seen, waiting for line to return high
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-low
//   rx          in   serial line, idle high, asynchronous to clk
//   rd_en       in   pop FIFO head (ignored when empty)
//   rd_data     out  FIFO head (first-word fall-through)
//   empty       out  FIFO holds no bytes
//   full        out  FIFO holds FIFO_DEPTH bytes
//   frame_err   out  1-clk pulse, a stop bit sampled 0
//   parity_err  out  1-clk pulse, parity mismatch with good stop bits
//   overrun     out  1-clk pulse, good byte dropped because FIFO full
// ----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 19200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 empty,
    output logic                 full,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);

    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    logic                 r_sync1, r_sync2, r_sync3;
    logic [TW-1:0]        r_tick_cnt;
    logic [SW-1:0]        r_samp_cnt;
    logic [ST_W-1:0]      r_state;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bad;
    logic                 r_stop_bad;
    logic                 r_frame_err, r_parity_err, r_overrun;

    logic                 w_rx;
    logic                 w_fall;
    logic                 w_tick;
    logic                 w_samp_due;
    logic                 w_par_exp;
    logic                 w_last_stop;
    logic                 w_stop_fail;
    logic                 w_frame_fail;
    logic                 w_par_fail;
    logic                 w_push;
    logic                 w_overrun;
    logic                 w_full;
    logic [ST_W-1:0]      w_state_nxt;

    // r_sync3 only serves edge detection; sampling uses r_sync2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_rx   = r_sync2;
    assign w_fall = r_sync3 & ~r_sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == TICK_LAST) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign w_tick = (r_tick_cnt == TICK_LAST);

    // Start bit is checked half a bit in; every later sample is one full
    // bit after the previous, which keeps all samples near mid-bit.
    assign w_samp_due = w_tick &
                        (r_samp_cnt == ((r_state == ST_START) ? HALF_LAST : FULL_LAST));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_samp_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_samp_cnt <= '0;
        end else if (w_tick) begin
            r_samp_cnt <= w_samp_due ? '0 : (r_samp_cnt + 1'b1);
        end
    end

    assign w_par_exp = (PARITY == PARITY_ODD) ? ~(^r_shift) : (^r_shift);

    assign w_last_stop  = (r_state == ST_STOP) & w_samp_due & (r_bit_cnt == STOP_LAST);
    assign w_stop_fail  = r_stop_bad | ~w_rx;
    assign w_frame_fail = w_last_stop & w_stop_fail;
    assign w_par_fail   = w_last_stop & ~w_stop_fail & r_par_bad;
    assign w_push       = w_last_stop & ~w_stop_fail & ~r_par_bad;
    // When full, a pop in the same clock makes room, so no overrun.
    assign w_overrun    = w_push & w_full & ~rd_en;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) w_state_nxt = ST_START;
            end
            ST_START: begin
                if (w_samp_due) w_state_nxt = w_rx ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_samp_due && (r_bit_cnt == DATA_LAST)) begin
                    w_state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (w_samp_due) w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (w_last_stop) w_state_nxt = w_stop_fail ? ST_BREAK_WAIT : ST_IDLE;
            end
            ST_BREAK_WAIT: begin
                if (w_rx) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_bad  <= 1'b0;
            r_stop_bad <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE) begin
                r_bit_cnt  <= '0;
                r_par_bad  <= 1'b0;
                r_stop_bad <= 1'b0;
            end else if (w_samp_due) begin
                case (r_state)
                    ST_DATA: begin
                        r_shift   <= {w_rx, r_shift[DATA_BITS-1:1]};
                        r_bit_cnt <= (r_bit_cnt == DATA_LAST) ? '0 : (r_bit_cnt + 1'b1);
                    end
                    ST_PARITY: begin
                        r_par_bad <= (w_rx != w_par_exp);
                    end
                    ST_STOP: begin
                        r_stop_bad <= w_stop_fail;
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_err  <= w_frame_fail;
            r_parity_err <= w_par_fail;
            r_overrun    <= w_overrun;
        end
    end

    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;
    assign full       = w_full;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_push),
        .i_wr_data (r_shift),
        .i_rd_en   (rd_en),
        .o_rd_data (rd_data),
        .o_empty   (empty),
        .o_full    (w_full)
    );

endmodule
